register_file: RTL and testbench

Thirty-two-entry, 32-bit MIPS general-purpose register file sitting directly downstream of the destination-register mux. It consumes the 5-bit destination number (rt, rd, or 31 for `jal`) as its write address. It accepts one write per clock from the write-back path and serves two combinational read ports to the decode stage plus one debug read port. `$zero` is hardwired. `$sp` and `$gp` reset to MIPS reference defaults.

---
 rtl/register_file.sv | 93 +++++++++
 tb/tb_register_file.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// MIPS general-purpose register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits.
// It takes one write per clock from write-back and serves two combinational
// read ports for decode plus one debug read port. Register 0 is hardwired to
// zero. Registers 28 ($gp) and 29 ($sp) reset to GP_RESET and SP_RESET.
//
// Ports:
//   clk        - single clock, state updates on the rising edge
//   reset      - asynchronous, active-high reset
//   RegWrite   - write enable
//   WriteReg   - destination register number
//   WriteData  - write-back value
//   ReadReg1/2 - source register numbers (rs / rt)
//   ReadData1/2- combinational read data
//   DebugReg   - debug observation register number
//   DebugData  - stored contents of DebugReg (never bypassed)
//   WriteCount - number of committed writes since reset (wraps)
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, a read port addressing the register
//                       being written in the same cycle returns WriteData
//                       (write-before-read). When undefined, reads always
//                       return the stored entry.
// -----------------------------------------------------------------------------
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h7FFF_EFFC,
    parameter logic [DATA_WIDTH-1:0] GP_RESET   = 32'h1000_8000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] DebugReg,
    output logic [DATA_WIDTH-1:0] DebugData,
    output logic [DATA_WIDTH-1:0] WriteCount
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned GP_IDX   = 28;
    localparam int unsigned SP_IDX   = 29;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic                  wr_en;

    // Writes to register 0 are dropped entirely, including the count.
    assign wr_en   = RegWrite && (WriteReg != '0);
    assign count_d = wr_en ? count_q + DATA_WIDTH'(1) : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (i == GP_IDX)
                    regs_q[i] <= GP_RESET;
                else if (i == SP_IDX)
                    regs_q[i] <= SP_RESET;
                else
                    regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            if (wr_en)
                regs_q[WriteReg] <= WriteData;
            count_q <= count_d;
        end
    end

    always_comb begin
        ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
        ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes register 0, so the zero forcing above holds.
        if (wr_en && (ReadReg1 == WriteReg))
            ReadData1 = WriteData;
        if (wr_en && (ReadReg2 == WriteReg))
            ReadData2 = WriteData;
`endif
        DebugData = (DebugReg == '0) ? '0 : regs_q[DebugReg];
    end

    assign WriteCount = count_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam logic [31:0] SP_DEF = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_DEF = 32'h1000_8000;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  DebugReg;
    logic [31:0] DebugData;
    logic [31:0] WriteCount;

    int n_vec;
    int n_bad;

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .SP_RESET  (SP_DEF),
        .GP_RESET  (GP_DEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .DebugReg  (DebugReg),
        .DebugData (DebugData),
        .WriteCount(WriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  dbg;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] edbg;
        logic [31:0] ecnt;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] mdl  [32];

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = 5'd29;
        ReadReg2  = 5'd28;
        DebugReg  = 5'd5;

        //                we    wreg   wdata          r1     r2     dbg    e1             e2             edbg           cnt
        vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd7,  5'd29, 32'hDEAD_BEEF, 32'h0000_0777, SP_DEF,        32'd2};
        vecs[1] = '{1'b1, 5'd31, 32'h0040_0010, 5'd8,  5'd31, 5'd28, 32'hDEAD_BEEF, 32'h0040_0010, GP_DEF,        32'd3};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'd3};
        vecs[3] = '{1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd8,  5'd5,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'd3};
        vecs[4] = '{1'b1, 5'd29, 32'h0000_1000, 5'd29, 5'd28, 5'd31, 32'h0000_1000, GP_DEF,        32'h0040_0010, 32'd4};
        vecs[5] = '{1'b1, 5'd9,  32'h1111_1111, 5'd9,  5'd9,  5'd9,  32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'd5};
        vecs[6] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd7,  5'd8,  32'h0000_0001, 32'h0000_0777, 32'hDEAD_BEEF, 32'd6};
        vecs[7] = '{1'b1, 5'd1,  32'h0000_0002, 5'd1,  5'd0,  5'd1,  32'h0000_0002, 32'h0,         32'h0000_0002, 32'd7};

        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl[28] = GP_DEF;
        mdl[29] = SP_DEF;

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        check("rst_sp",  ReadData1,  SP_DEF);
        check("rst_gp",  ReadData2,  GP_DEF);
        check("rst_dbg", DebugData,  32'h0);
        check("rst_cnt", WriteCount, 32'h0);

        // Edge under reset must not write.
        RegWrite  = 1'b1;
        WriteReg  = 5'd10;
        WriteData = 32'hFFFF_0000;
        DebugReg  = 5'd10;
        @(posedge clk); #1;
        check("rst_edge_nowrite", DebugData,  32'h0);
        check("rst_edge_cnt",     WriteCount, 32'h0);

        // Deassert with a write presented: first edge writes.
        @(negedge clk);
        reset     = 1'b0;
        WriteReg  = 5'd7;
        WriteData = 32'h0000_0777;
        DebugReg  = 5'd7;
        #1;
        check("deassert_cnt", WriteCount, 32'h0);
        @(posedge clk); #1;
        RegWrite = 1'b0;
        check("deassert_wr",     DebugData,  32'h0000_0777);
        check("deassert_wr_cnt", WriteCount, 32'd1);
        mdl[7] = 32'h0000_0777;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            RegWrite  = vecs[i].we;
            WriteReg  = vecs[i].wreg;
            WriteData = vecs[i].wdata;
            ReadReg1  = vecs[i].r1;
            ReadReg2  = vecs[i].r2;
            DebugReg  = vecs[i].dbg;
            @(posedge clk); #1;
            RegWrite = 1'b0;
            #1;
            check($sformatf("vec%0d_rd1", i), ReadData1,  vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), ReadData2,  vecs[i].e2);
            check($sformatf("vec%0d_dbg", i), DebugData,  vecs[i].edbg);
            check($sformatf("vec%0d_cnt", i), WriteCount, vecs[i].ecnt);
            if (vecs[i].we && vecs[i].wreg != 5'd0) mdl[vecs[i].wreg] = vecs[i].wdata;
        end

        // Whole-array sweep through the debug port.
        for (int r = 0; r < 32; r++) begin
            DebugReg = 5'(r);
            #1;
            check($sformatf("sweep_r%0d", r), DebugData, mdl[r]);
        end

        // Same-cycle read of the register being written.
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd9;
        WriteData = 32'h2222_2222;
        ReadReg1  = 5'd9;
        DebugReg  = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before", ReadData1, 32'h2222_2222);
`else
        check("rdw_before", ReadData1, 32'h1111_1111);
`endif
        check("rdw_dbg_before", DebugData, 32'h1111_1111);
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        check("rdw_after",     ReadData1,  32'h2222_2222);
        check("rdw_dbg_after", DebugData,  32'h2222_2222);
        check("rdw_cnt",       WriteCount, 32'd8);

        // RegWrite low: unknown address/data must change nothing.
        @(negedge clk);
        RegWrite  = 1'b0;
        WriteReg  = 'x;
        WriteData = 'x;
        ReadReg1  = 5'd8;
        @(posedge clk); #1;
        check("nowe_rd",  ReadData1,  32'hDEAD_BEEF);
        check("nowe_cnt", WriteCount, 32'd8);

        // Reset mid-operation after three writes to reg 10.
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd10;
        WriteData = 32'h0000_0005;
        ReadReg1  = 5'd10;
        ReadReg2  = 5'd29;
        repeat (3) @(posedge clk);
        #1;
        check("midop_wr",  ReadData1,  32'h0000_0005);
        check("midop_cnt", WriteCount, 32'd11);
        #2 reset = 1'b1;
        #1;
        check("midop_rst_r10", ReadData1,  32'h0);
        check("midop_rst_sp",  ReadData2,  SP_DEF);
        check("midop_rst_cnt", WriteCount, 32'h0);
        @(posedge clk); #1;
        check("midop_edge_r10", ReadData1,  32'h0);
        check("midop_edge_cnt", WriteCount, 32'h0);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b0;
        @(posedge clk); #1;
        check("post_rst_cnt", WriteCount, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
